// File: rtl/dds_pkg.sv
// Shared types, default sizes and helpers for the DDS channel scheduler.
package dds_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_ACC_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/dds_channel_scheduler_if.sv
// Configuration write bus between the register host (master) and the scheduler (slave).
interface dds_channel_scheduler_if #(
    parameter int N     = dds_pkg::DEF_N,
    parameter int NCH   = dds_pkg::DEF_NCH,
    parameter int ACC_W = dds_pkg::DEF_ACC_W
);

    localparam int CHW = dds_pkg::ch_w(NCH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [ACC_W-1:0] cfg_ftw;
    logic [N:0]       cfg_amp;
    logic             cfg_en;
    logic             cfg_phase_clr;

    modport master (
        output cfg_valid, cfg_ch, cfg_ftw, cfg_amp, cfg_en, cfg_phase_clr,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_ftw, cfg_amp, cfg_en, cfg_phase_clr,
        output cfg_ready
    );

endinterface

// File: rtl/dds_channel_regs.sv
// Per-channel FTW/amplitude/enable/accumulator storage with one write port,
// one slot-indexed read port and an accumulate strobe for the slot being read.
module dds_channel_regs
    import dds_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int NCH   = DEF_NCH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CHW   = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [ACC_W-1:0] wr_ftw,
    input  logic [N:0]       wr_amp,
    input  logic             wr_en,
    input  logic             wr_phase_clr,
    input  logic [CHW-1:0]   rd_slot,
    input  logic             acc_stb,
    output logic [N:0]       rd_phase,
    output logic [N:0]       rd_amp,
    output logic             rd_en
);

    logic [ACC_W-1:0] ftw_q [NCH];
    logic [ACC_W-1:0] ftw_d [NCH];
    logic [ACC_W-1:0] acc_q [NCH];
    logic [ACC_W-1:0] acc_d [NCH];
    logic [N:0]       amp_q [NCH];
    logic [N:0]       amp_d [NCH];
    logic             en_q  [NCH];
    logic             en_d  [NCH];

    // Writes only happen while idle and accumulation only while scanning,
    // so the two never collide; the write is applied last regardless.
    always_comb begin
        ftw_d = ftw_q;
        acc_d = acc_q;
        amp_d = amp_q;
        en_d  = en_q;
        if (acc_stb) begin
            acc_d[rd_slot] = acc_q[rd_slot] + ftw_q[rd_slot];
        end
        if (wr_valid) begin
            ftw_d[wr_ch] = wr_ftw;
            amp_d[wr_ch] = wr_amp;
            en_d[wr_ch]  = wr_en;
            if (wr_phase_clr) begin
                acc_d[wr_ch] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ftw_q[i] <= '0;
                acc_q[i] <= '0;
                amp_q[i] <= '0;
                en_q[i]  <= 1'b0;
            end
        end else begin
            ftw_q <= ftw_d;
            acc_q <= acc_d;
            amp_q <= amp_d;
            en_q  <= en_d;
        end
    end

    assign rd_phase = acc_q[rd_slot][ACC_W-1 -: N+1];
    assign rd_amp   = amp_q[rd_slot];
    assign rd_en    = en_q[rd_slot];

endmodule

// File: rtl/dds_channel_scheduler.sv
// Time-multiplexes one external phase/amplitude converter across NCH DDS channels,
// one slot per clock per sample tick, and registers each enabled channel's product.
module dds_channel_scheduler
    import dds_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int NCH   = DEF_NCH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CHW   = ch_w(NCH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    smp_tick,
    input  logic                    ovr_clr,
    dds_channel_scheduler_if.slave  cfg,
    output logic [N:0]              lut_phase,
    output logic [N:0]              lut_amp,
    input  logic [2*N+1:0]          lut_data,
    output logic                    smp_valid,
    output logic [CHW-1:0]          smp_ch,
    output logic [2*N+1:0]          smp_data,
    output logic                    busy,
    output logic                    overrun
);

    state_t         state_q, state_d;
    logic [CHW-1:0] slot_q, slot_d;
    logic           overrun_q, overrun_d;
    logic           smp_valid_q, smp_valid_d;
    logic [CHW-1:0] smp_ch_q, smp_ch_d;
    logic [2*N+1:0] smp_data_q, smp_data_d;

    logic           wr_accept;
    logic           slot_active;
    logic [N:0]     rd_phase;
    logic [N:0]     rd_amp;
    logic           rd_en;

    // Configuration is frozen for the whole frame by only accepting writes in IDLE.
    assign cfg.cfg_ready = (state_q == IDLE);
    assign wr_accept     = cfg.cfg_valid && cfg.cfg_ready;
    assign busy          = (state_q != IDLE);
    assign slot_active   = (state_q == SCAN) && rd_en;

    dds_channel_regs #(
        .N     (N),
        .NCH   (NCH),
        .ACC_W (ACC_W),
        .CHW   (CHW)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_accept),
        .wr_ch        (cfg.cfg_ch),
        .wr_ftw       (cfg.cfg_ftw),
        .wr_amp       (cfg.cfg_amp),
        .wr_en        (cfg.cfg_en),
        .wr_phase_clr (cfg.cfg_phase_clr),
        .rd_slot      (slot_q),
        .acc_stb      (slot_active),
        .rd_phase     (rd_phase),
        .rd_amp       (rd_amp),
        .rd_en        (rd_en)
    );

    // Converter inputs come straight from flopped slot state; idle or disabled slots present zero.
    assign lut_phase = slot_active ? rd_phase : '0;
    assign lut_amp   = slot_active ? rd_amp   : '0;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            IDLE: begin
                if (smp_tick) begin
                    state_d = SCAN;
                    slot_d  = '0;
                end
            end
            SCAN: begin
                slot_d = slot_q + 1'b1;
                if (slot_q == CHW'(NCH - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A tick that lands mid-frame is dropped; a coincident clear loses to the new overrun.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (smp_tick && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        smp_valid_d = slot_active;
        smp_ch_d    = smp_ch_q;
        smp_data_d  = smp_data_q;
        if (slot_active) begin
            smp_ch_d   = slot_q;
            smp_data_d = lut_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            overrun_q   <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            overrun_q   <= overrun_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_data_q  <= smp_data_d;
        end
    end

    assign overrun   = overrun_q;
    assign smp_valid = smp_valid_q;
    assign smp_ch    = smp_ch_q;
    assign smp_data  = smp_data_q;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Bench for dds_channel_scheduler: a per-cycle control table, hand-written frame
// sequences, and a sample scoreboard fed by a small channel model.
module tb_dds_channel_scheduler;

    localparam int N     = 8;
    localparam int NCH   = 4;
    localparam int ACC_W = 24;
    localparam int CHW   = 2;
    localparam int DW    = 2 * N + 2;

    typedef logic [N:0]       amp_t;
    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [CHW-1:0]   ch_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          smp_tick;
    logic          ovr_clr;
    logic [N:0]    lut_phase;
    logic [N:0]    lut_amp;
    logic [DW-1:0] lut_data;
    logic          smp_valid;
    logic [CHW-1:0] smp_ch;
    logic [DW-1:0] smp_data;
    logic          busy;
    logic          overrun;

    dds_channel_scheduler_if #(.N(N), .NCH(NCH), .ACC_W(ACC_W)) cfg_if ();

    dds_channel_scheduler #(.N(N), .NCH(NCH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .smp_tick  (smp_tick),
        .ovr_clr   (ovr_clr),
        .cfg       (cfg_if.slave),
        .lut_phase (lut_phase),
        .lut_amp   (lut_amp),
        .lut_data  (lut_data),
        .smp_valid (smp_valid),
        .smp_ch    (smp_ch),
        .smp_data  (smp_data),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Converter stand-in: 512-entry offset sine table times amplitude.
    int sine_tab [512];
    assign lut_data = DW'(sine_tab[lut_phase] * int'(lut_amp));

    typedef struct {
        int ch;
        int data;
    } sample_t;

    typedef struct {
        bit tick, acc_tick, clr_ovr, wr;
        int ch, ftw, amp;
        bit en;
        bit e_busy, e_ready, e_ovr, e_valid;
        int e_phase, e_amp;
    } vec_t;

    acc_t    m_acc [NCH];
    acc_t    m_ftw [NCH];
    amp_t    m_amp [NCH];
    bit      m_en  [NCH];
    sample_t exp_q [$];
    sample_t mon_s;
    vec_t    vecs  [$];
    int      checks = 0;
    int      errors = 0;

    function automatic int sine_ref(input int p);
        return int'($floor(256.0 + 255.0 * $sin(6.283185307179586 * real'(p) / 512.0) + 0.5));
    endfunction

    function automatic vec_t mk(input bit tick, acc_tick, clr_ovr, wr, input int ch, ftw, amp,
                                input bit en, e_busy, e_ready, e_ovr, e_valid, input int e_phase, e_amp);
        vec_t v;
        v.tick = tick; v.acc_tick = acc_tick; v.clr_ovr = clr_ovr; v.wr = wr;
        v.ch = ch; v.ftw = ftw; v.amp = amp; v.en = en;
        v.e_busy = e_busy; v.e_ready = e_ready; v.e_ovr = e_ovr; v.e_valid = e_valid;
        v.e_phase = e_phase; v.e_amp = e_amp;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = '0; m_ftw[i] = '0; m_amp[i] = '0; m_en[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic modelWrite(input int ch, input int ftw, input int amp, input bit en, input bit clr);
        m_ftw[ch] = acc_t'(ftw);
        m_amp[ch] = amp_t'(amp);
        m_en[ch]  = en;
        if (clr) m_acc[ch] = '0;
    endtask

    // An accepted tick produces one expected sample per enabled channel, in slot order.
    task automatic modelTick();
        sample_t s;
        for (int c = 0; c < NCH; c++) begin
            if (m_en[c]) begin
                s.ch   = c;
                s.data = sine_ref(int'(m_acc[c][ACC_W-1 -: N+1])) * int'(m_amp[c]);
                exp_q.push_back(s);
                m_acc[c] = m_acc[c] + m_ftw[c];
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        smp_tick               = v.tick;
        ovr_clr                = v.clr_ovr;
        cfg_if.cfg_valid       = v.wr;
        cfg_if.cfg_ch          = ch_t'(v.ch);
        cfg_if.cfg_ftw         = acc_t'(v.ftw);
        cfg_if.cfg_amp         = amp_t'(v.amp);
        cfg_if.cfg_en          = v.en;
        cfg_if.cfg_phase_clr   = 1'b0;
        @(posedge clk); #1;
        if (v.wr) modelWrite(v.ch, v.ftw, v.amp, v.en, 1'b0);
        if (v.acc_tick) modelTick();
    endtask

    task automatic writeChannel(input int ch, input int ftw, input int amp, input bit en, input bit clr);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_ch        = ch_t'(ch);
        cfg_if.cfg_ftw       = acc_t'(ftw);
        cfg_if.cfg_amp       = amp_t'(amp);
        cfg_if.cfg_en        = en;
        cfg_if.cfg_phase_clr = clr;
        @(posedge clk); #1;
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_phase_clr = 1'b0;
        modelWrite(ch, ftw, amp, en, clr);
    endtask

    task automatic pulseTick();
        smp_tick = 1'b1;
        @(posedge clk); #1;
        smp_tick = 1'b0;
        modelTick();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic doReset(input int exp_pending);
        checkOutput("pending samples before reset", exp_q.size(), exp_pending);
        reset = 1'b1;
        idleCycles(2);
        reset = 1'b0;
        modelReset();
    endtask

    always @(negedge clk) begin
        if (!reset && smp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected sample: got ch %0d data %0d, want none", smp_ch, smp_data);
            end else begin
                mon_s = exp_q.pop_front();
                checkOutput("sample ch", 32'(smp_ch), mon_s.ch);
                checkOutput("sample data", 32'(smp_data), mon_s.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int h1_ph [3] = '{0, 2, 4};
        int h1_d  [3] = '{256, 262, 269};
        int h2_ph [3] = '{0, 511, 510};

        for (int p = 0; p < 512; p++) sine_tab[p] = sine_ref(p);
        reset = 1'b1;
        smp_tick = 1'b0;
        ovr_clr = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_ftw = '0;
        cfg_if.cfg_amp = '0;
        cfg_if.cfg_en = 1'b0;
        cfg_if.cfg_phase_clr = 1'b0;
        modelReset();
        idleCycles(2);

        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset overrun", 32'(overrun), 0);
        checkOutput("reset cfg_ready", 32'(cfg_if.cfg_ready), 1);
        checkOutput("reset smp_valid", 32'(smp_valid), 0);
        checkOutput("reset smp_ch", 32'(smp_ch), 0);
        checkOutput("reset smp_data", 32'(smp_data), 0);
        checkOutput("reset lut_phase", 32'(lut_phase), 0);
        checkOutput("reset lut_amp", 32'(lut_amp), 0);
        reset = 1'b0;

        // tick acc clr wr | ch ftw amp en | busy ready ovr valid | phase amp (values after the edge)
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 1,0,0,0, 0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0,0, 0,0));
        for (int c = 0; c < 4; c++) vecs.push_back(mk(0,0,0,1, c,0,c+1,1, 0,1,0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 1,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,1, 0,2));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0, 1,0,1,1, 0,3));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,1,0, 0,0));
        vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,1,0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 1,0,0,0, 0,1));
        vecs.push_back(mk(1,0,1,0, 0,0,0,0, 1,0,1,1, 0,2));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,3));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,1,0, 0,0));
        vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,1,0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 1,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,1, 0,2));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,1, 0,3));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,1, 0,4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,1, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0, 0,1,1,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 1,0,1,0, 0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,2));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,3));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1,1, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,1,0, 0,0));
        vecs.push_back(mk(0,0,1,0, 0,0,0,0, 0,1,0,0, 0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d cfg_ready", i), 32'(cfg_if.cfg_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("v%0d overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
            checkOutput($sformatf("v%0d smp_valid", i), 32'(smp_valid), 32'(vecs[i].e_valid));
            checkOutput($sformatf("v%0d lut_phase", i), 32'(lut_phase), vecs[i].e_phase);
            checkOutput($sformatf("v%0d lut_amp", i), 32'(lut_amp), vecs[i].e_amp);
        end
        smp_tick = 1'b0;
        ovr_clr = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        idleCycles(2);

        // Single sine channel: phase steps by 2 per frame, sample lands two cycles after the tick.
        doReset(0);
        writeChannel(0, 24'h010000, 1, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            pulseTick();
            checkOutput($sformatf("h1 frame%0d lut_phase", f), 32'(lut_phase), h1_ph[f]);
            idleCycles(1);
            checkOutput($sformatf("h1 frame%0d smp_valid", f), 32'(smp_valid), 1);
            checkOutput($sformatf("h1 frame%0d smp_ch", f), 32'(smp_ch), 0);
            checkOutput($sformatf("h1 frame%0d smp_data", f), 32'(smp_data), h1_d[f]);
            idleCycles(5);
        end

        // Accumulator wrap on ch1, then a phase-clear write.
        doReset(0);
        writeChannel(1, 24'hFF8000, 1, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            pulseTick();
            idleCycles(1);
            checkOutput($sformatf("h2 frame%0d lut_phase", f), 32'(lut_phase), h2_ph[f]);
            idleCycles(5);
        end
        writeChannel(1, 24'hFF8000, 1, 1'b1, 1'b1);
        pulseTick();
        idleCycles(1);
        checkOutput("h2 after clear lut_phase", 32'(lut_phase), 0);
        checkOutput("h2 after clear lut_amp", 32'(lut_amp), 1);
        idleCycles(5);

        // Reset asserted in the middle of SCAN slot 1.
        doReset(0);
        writeChannel(1, 24'h100000, 3, 1'b1, 1'b0);
        writeChannel(0, 24'h000000, 2, 1'b1, 1'b0);
        pulseTick();
        idleCycles(6);
        pulseTick();
        idleCycles(1);
        checkOutput("h3 slot1 lut_phase", 32'(lut_phase), 32);
        checkOutput("h3 slot1 lut_amp", 32'(lut_amp), 3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("h3 async lut_phase", 32'(lut_phase), 0);
        checkOutput("h3 async lut_amp", 32'(lut_amp), 0);
        checkOutput("h3 async smp_valid", 32'(smp_valid), 0);
        checkOutput("h3 async smp_data", 32'(smp_data), 0);
        checkOutput("h3 async busy", 32'(busy), 0);
        checkOutput("h3 async cfg_ready", 32'(cfg_if.cfg_ready), 1);
        checkOutput("h3 pending samples", exp_q.size(), 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
        writeChannel(1, 24'h100000, 3, 1'b1, 1'b0);
        pulseTick();
        idleCycles(1);
        checkOutput("h3 fresh lut_phase", 32'(lut_phase), 0);
        idleCycles(6);

        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
